// File: rtl/branch_resolve_unit_if.sv
// ============================================================================
// Module   : branch_resolve_unit_if
// Purpose  : Bundles the request, result, statistics and predictor-lookup
//            signals of the branch resolution stage into one interface.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_resolve_unit_if #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16,
    parameter int STAT_W = 16
);
    // Request side
    logic              in_valid_pi;
    logic [2:0]        br_op_pi;
    logic              signed_pi;
    logic [DATA_W-1:0] reg1_data_pi;
    logic [DATA_W-1:0] reg2_data_pi;
    logic              alu_carry_bit_pi;
    logic [PC_W-1:0]   pc_pi;
    logic [PC_W-1:0]   target_pi;
    logic              pred_taken_pi;
    logic              flush_pi;

    // Fetch-time predictor lookup
    logic [PC_W-1:0]   fetch_pc_pi;
    logic              predict_taken_po;

    // Result side
    logic              out_valid_po;
    logic              is_branch_taken_po;
    logic              mispredict_po;
    logic [PC_W-1:0]   redirect_pc_po;
    logic [STAT_W-1:0] branch_count_po;
    logic [STAT_W-1:0] mispredict_count_po;

    modport master (
        output in_valid_pi, br_op_pi, signed_pi, reg1_data_pi, reg2_data_pi,
        output alu_carry_bit_pi, pc_pi, target_pi, pred_taken_pi, flush_pi,
        output fetch_pc_pi,
        input  predict_taken_po, out_valid_po, is_branch_taken_po, mispredict_po,
        input  redirect_pc_po, branch_count_po, mispredict_count_po
    );

    modport slave (
        input  in_valid_pi, br_op_pi, signed_pi, reg1_data_pi, reg2_data_pi,
        input  alu_carry_bit_pi, pc_pi, target_pi, pred_taken_pi, flush_pi,
        input  fetch_pc_pi,
        output predict_taken_po, out_valid_po, is_branch_taken_po, mispredict_po,
        output redirect_pc_po, branch_count_po, mispredict_count_po
    );
endinterface

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : One-cycle registered branch resolution with a 2-bit saturating
//            predictor table and saturating branch/mispredict statistics.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_unit #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16,
    parameter int IDX_W  = 4,
    parameter int STAT_W = 16
) (
    input  wire logic               clk_pi,
    input  wire logic               reset_pi,
    branch_resolve_unit_if.slave    bus
);

    localparam int         c_DEPTH  = 2 ** IDX_W;
    localparam logic [2:0] c_OP_NONE  = 3'd0;
    localparam logic [2:0] c_OP_EQ    = 3'd1;
    localparam logic [2:0] c_OP_GE    = 3'd2;
    localparam logic [2:0] c_OP_LE    = 3'd3;
    localparam logic [2:0] c_OP_CARRY = 3'd4;
    localparam logic [2:0] c_OP_NE    = 3'd5;
    localparam logic [2:0] c_OP_GT    = 3'd6;
    localparam logic [2:0] c_OP_LT    = 3'd7;
    localparam logic [1:0] c_CTR_INIT = 2'b01;

    logic [1:0]        r_ctr [c_DEPTH];
    logic              r_out_valid;
    logic              r_taken;
    logic              r_mispredict;
    logic [PC_W-1:0]   r_redirect_pc;
    logic [STAT_W-1:0] r_branch_cnt;
    logic [STAT_W-1:0] r_mispredict_cnt;

    logic              w_eq;
    logic              w_lt;
    logic              w_gt;
    logic              w_taken;
    logic              w_accept;
    logic              w_mispredict;
    logic [IDX_W-1:0]  w_idx;
    logic [IDX_W-1:0]  w_fetch_idx;
    logic [1:0]        w_ctr_cur;
    logic [1:0]        w_ctr_next;
    logic [PC_W-1:0]   w_redirect_pc;

    // ------------------------------------------------------------------
    // Condition evaluation
    // ------------------------------------------------------------------
    assign w_eq = (bus.reg1_data_pi == bus.reg2_data_pi);

    always_comb begin
        w_lt = 1'b0;
        w_gt = 1'b0;
        if (bus.signed_pi) begin
            w_lt = ($signed(bus.reg1_data_pi) < $signed(bus.reg2_data_pi));
            w_gt = ($signed(bus.reg2_data_pi) < $signed(bus.reg1_data_pi));
        end else begin
            w_lt = (bus.reg1_data_pi < bus.reg2_data_pi);
            w_gt = (bus.reg2_data_pi < bus.reg1_data_pi);
        end
    end

    always_comb begin
        w_taken = 1'b0;
        case (bus.br_op_pi)
            c_OP_NONE:  w_taken = 1'b0;
            c_OP_EQ:    w_taken = w_eq;
            c_OP_GE:    w_taken = ~w_lt;
            c_OP_LE:    w_taken = ~w_gt;
            c_OP_CARRY: w_taken = bus.alu_carry_bit_pi;
            c_OP_NE:    w_taken = ~w_eq;
            c_OP_GT:    w_taken = w_gt;
            c_OP_LT:    w_taken = w_lt;
            default:    w_taken = 1'b0;
        endcase
    end

    assign w_accept      = bus.in_valid_pi & (bus.br_op_pi != c_OP_NONE) & ~bus.flush_pi;
    assign w_mispredict  = (w_taken != bus.pred_taken_pi);
    assign w_redirect_pc = w_taken ? bus.target_pi : (bus.pc_pi + PC_W'(1));

    // ------------------------------------------------------------------
    // Predictor table: saturating 2-bit counters indexed by low PC bits
    // ------------------------------------------------------------------
    assign w_idx     = bus.pc_pi[IDX_W-1:0];
    assign w_ctr_cur = r_ctr[w_idx];

    always_comb begin
        w_ctr_next = w_ctr_cur;
        if (w_taken) begin
            if (w_ctr_cur != 2'b11) w_ctr_next = w_ctr_cur + 2'b01;
        end else begin
            if (w_ctr_cur != 2'b00) w_ctr_next = w_ctr_cur - 2'b01;
        end
    end

    always_ff @(posedge clk_pi or posedge reset_pi) begin
        if (reset_pi) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_ctr[i] <= c_CTR_INIT;
            end
        end else if (w_accept) begin
            r_ctr[w_idx] <= w_ctr_next;
        end
    end

    // Lookup reads the registered table, so a same-cycle update is seen next cycle
    assign w_fetch_idx          = bus.fetch_pc_pi[IDX_W-1:0];
    assign bus.predict_taken_po = r_ctr[w_fetch_idx][1];

    // ------------------------------------------------------------------
    // Result and statistics registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_pi or posedge reset_pi) begin
        if (reset_pi) begin
            r_out_valid      <= 1'b0;
            r_taken          <= 1'b0;
            r_mispredict     <= 1'b0;
            r_redirect_pc    <= '0;
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_taken       <= w_taken;
                r_mispredict  <= w_mispredict;
                r_redirect_pc <= w_redirect_pc;
                if (~&r_branch_cnt) begin
                    r_branch_cnt <= r_branch_cnt + STAT_W'(1);
                end
                if (w_mispredict && (~&r_mispredict_cnt)) begin
                    r_mispredict_cnt <= r_mispredict_cnt + STAT_W'(1);
                end
            end
        end
    end

    assign bus.out_valid_po        = r_out_valid;
    assign bus.is_branch_taken_po  = r_taken;
    assign bus.mispredict_po       = r_mispredict & r_out_valid;
    assign bus.redirect_pc_po      = r_redirect_pc;
    assign bus.branch_count_po     = r_branch_cnt;
    assign bus.mispredict_count_po = r_mispredict_cnt;

    // Only the low fetch-PC bits address the table
    logic w_unused_fetch_hi;
    assign w_unused_fetch_hi = ^bus.fetch_pc_pi;

endmodule

`default_nettype wire
